// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
// Generates the audio sample-rate tick and starts one SPI ADC conversion per tick.
// It captures the DATA_W-bit result and hands it to the filter bank through a
// single-entry buffer. Overruns are reported on a sticky flag.
//
// Optional feature: define ADC_TIMEOUT_EN to add a CONVERT watchdog. If spi_ready
// does not arrive within TIMEOUT cycles, the watchdog aborts the conversion and
// sets timeout_err. Without the macro, timeout_err is tied to 0.
//
// Output handshake: sample_valid=1 means sample_out holds an unconsumed sample.
// The consumer takes it in any cycle where sample_valid=1 and sample_ready=1.
// A new capture always replaces the buffer contents. If the old sample was not
// taken in that same cycle, the new sample overwrites it and overrun is raised.
module adc_sample_sequencer #(
    parameter int SAMPLE_DIV = 2268,
    parameter int DATA_W     = 12,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              spi_ready,
    input  logic              spi_busy,
    input  logic [15:0]       spi_data,
    output logic              spi_start,
    output logic              cs_n,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, START, CONVERT, CAPTURE} state_t;

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              tick;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              overrun_set;
    logic              cs_n_q, cs_n_d;
    logic              start_q, start_d;
    logic              load;
    logic              timeout_hit;

    // spi_busy is monitor-only, and only the low DATA_W bits of spi_data are captured.
    logic unused_inputs;
    assign unused_inputs = ^{spi_busy, spi_data};

    // Sample-rate counter: free-runs while enabled and is parked at 0 otherwise.
    always_comb begin
        tick  = enable && (cnt_q == DIV_LAST);
        cnt_d = cnt_q + 16'd1;
        if (!enable || tick) begin
            cnt_d = 16'd0;
        end
    end

    // Sample-rate counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef ADC_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wd_q, wd_d;
    logic        terr_q, terr_d;

    // Watchdog: counts cycles spent in CONVERT and fires on the TIMEOUT-th one.
    always_comb begin
        wd_d        = (state_q == CONVERT) ? wd_q + 16'd1 : 16'd0;
        timeout_hit = (state_q == CONVERT) && !spi_ready && (wd_q == TO_LAST);
        terr_d      = terr_q | timeout_hit;
    end

    // Watchdog count and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= 16'd0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM next state. The outputs are decoded from the next state so that the
    // registered cs_n and spi_start line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE:    if (tick) state_d = START;
            START:   state_d = CONVERT;
            CONVERT: begin
                if (spi_ready) begin
                    data_d  = spi_data[DATA_W-1:0];
                    state_d = CAPTURE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cs_n_d  = !((state_d == START) || (state_d == CONVERT));
        start_d = (state_d == START);
    end

    // FSM state, captured conversion result, and registered chip-select/start outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cs_n_q  <= 1'b1;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cs_n_q  <= cs_n_d;
            start_q <= start_d;
        end
    end

    // Output buffer and overrun detection. A dropped tick and a lost sample both count.
    always_comb begin
        load        = (state_q == CAPTURE);
        sample_d    = sample_q;
        valid_d     = valid_q;
        if (load) begin
            sample_d = data_q;
            valid_d  = 1'b1;
        end else if (sample_ready) begin
            valid_d  = 1'b0;
        end
        overrun_set = (tick && (state_q != IDLE)) || (load && valid_q && !sample_ready);
        overrun_d   = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Output buffer and overrun registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign spi_start    = start_q;
    assign cs_n         = cs_n_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer (SAMPLE_DIV=2268, DATA_W=12).
// Inputs change and outputs are observed on the falling clock edge.
module tb_adc_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        spi_ready;
    logic        spi_busy;
    logic [15:0] spi_data;
    logic        spi_start;
    logic        cs_n;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        overrun_clr;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    adc_sample_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .spi_ready    (spi_ready),
        .spi_busy     (spi_busy),
        .spi_data     (spi_data),
        .spi_start    (spi_start),
        .cs_n         (cs_n),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .timeout_err  (timeout_err)
    );

    // 100 MHz clock and a free-running cycle count used to measure periods.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the next spi_start pulse; n = falling edges waited.
    task automatic wait_start(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spi_start !== 1'b1 && n < limit);
        chk("start_seen", spi_start, 1);
        chk("cs_in_start", cs_n, 0);
    endtask

    // Called on the spi_start edge. Returns responds with spi_ready after `delay`
    // edges and returns on the CAPTURE edge. drop_at>0 lowers enable at that edge.
    task automatic convert(input logic [15:0] data, input int delay, input int drop_at,
                           output int starts);
        starts = 0;
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("start_one_cycle", spi_start, 0);
                chk("cs_in_convert", cs_n, 0);
            end
            if (spi_start === 1'b1) starts++;
            if (i == drop_at) enable = 1'b0;
        end
        spi_ready = 1'b1;
        spi_data  = data;
        @(negedge clk);
        spi_ready = 1'b0;
        spi_data  = 16'h0000;
        chk("cs_in_capture", cs_n, 1);
    endtask

    initial begin
        int n;
        int starts;
        int t0;

        rst = 1'b1; enable = 1'b0; spi_ready = 1'b0; spi_busy = 1'b0;
        spi_data = 16'h0000; sample_ready = 1'b1; overrun_clr = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_start", spi_start, 0);

        // Basic capture: first start 2268 cycles after enable, sample 2 cycles after ready
        enable = 1'b1;
        wait_start(3000, n);
        chk("first_start_latency", n, 2268);
        t0 = cyc;
        convert(16'h0ABC, 40, -1, starts);
        chk("valid_in_capture", sample_valid, 0);
        @(negedge clk);
        chk("t1_valid", sample_valid, 1);
        chk("t1_sample", sample_out, 12'hABC);
        chk("t1_overrun", overrun, 0);
        @(negedge clk);
        chk("t1_valid_one_cycle", sample_valid, 0);
        wait_start(3000, n);
        chk("tick_period", cyc - t0, 2268);
        convert(16'h0ABC, 40, -1, starts);
        @(negedge clk);
        chk("t1b_sample", sample_out, 12'hABC);
        chk("t1b_overrun", overrun, 0);
        @(negedge clk);

        // Consumer stalled: second sample overwrites the first, overrun set (set beats clr)
        sample_ready = 1'b0;
        wait_start(3000, n);
        convert(16'h0111, 40, -1, starts);
        @(negedge clk);
        chk("t2_valid_111", sample_valid, 1);
        chk("t2_sample_111", sample_out, 12'h111);
        chk("t2_overrun_0", overrun, 0);
        wait_start(3000, n);
        convert(16'h0222, 40, -1, starts);
        overrun_clr = 1'b1;
        @(negedge clk);
        chk("t2_sample_222", sample_out, 12'h222);
        chk("t2_valid_222", sample_valid, 1);
        chk("t2_overrun_set_wins", overrun, 1);
        @(negedge clk);
        chk("t2_overrun_cleared", overrun, 0);
        overrun_clr = 1'b0;
        chk("t2_valid_held", sample_valid, 1);

        // Consume and load in the same cycle: no overrun, valid stays 1
        wait_start(3000, n);
        convert(16'h0333, 40, -1, starts);
        sample_ready = 1'b1;
        @(negedge clk);
        chk("t2_swap_valid", sample_valid, 1);
        chk("t2_swap_sample", sample_out, 12'h333);
        chk("t2_swap_overrun", overrun, 0);
        @(negedge clk);
        chk("t2_swap_drained", sample_valid, 0);

        // Slow conversion: the tick during CONVERT is dropped and flagged
        wait_start(3000, n);
        t0 = cyc;
        convert(16'hF444, 2300, -1, starts);
        chk("t3_extra_starts", starts, 0);
        chk("t3_overrun", overrun, 1);
        @(negedge clk);
        chk("t3_sample_trunc", sample_out, 12'h444);
        chk("t3_valid", sample_valid, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("t3_overrun_clr", overrun, 0);
        wait_start(3000, n);
        chk("t3_period_kept", cyc - t0, 2 * 2268);

        // enable drops mid-conversion: sample still delivered, then no more starts
        convert(16'h0555, 40, 5, starts);
        @(negedge clk);
        chk("t4_valid", sample_valid, 1);
        chk("t4_sample", sample_out, 12'h555);
        starts = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (spi_start === 1'b1) starts++;
        end
        chk("t4_no_start", starts, 0);
        chk("t4_cs_idle", cs_n, 1);
        enable = 1'b1;
        wait_start(3000, n);
        chk("t4_counter_held_0", n, 2268);

        // Reset in CONVERT with valid and overrun set
        sample_ready = 1'b0;
        convert(16'h0666, 10, -1, starts);
        @(negedge clk);
        chk("t5_sample_666", sample_out, 12'h666);
        wait_start(3000, n);
        convert(16'h0777, 10, -1, starts);
        @(negedge clk);
        chk("t5_pre_overrun", overrun, 1);
        chk("t5_pre_valid", sample_valid, 1);
        wait_start(3000, n);
        repeat (3) @(negedge clk);
        chk("t5_pre_cs", cs_n, 0);
        rst = 1'b1;
        #1;
        chk("t5_rst_cs_n", cs_n, 1);
        chk("t5_rst_start", spi_start, 0);
        chk("t5_rst_valid", sample_valid, 0);
        chk("t5_rst_sample", sample_out, 0);
        chk("t5_rst_overrun", overrun, 0);
        chk("t5_rst_timeout", timeout_err, 0);
        @(negedge clk);
        rst = 1'b0;
        sample_ready = 1'b1;
        wait_start(3000, n);
        chk("t5_restart_latency", n, 2268);
        convert(16'h0888, 40, -1, starts);
        @(negedge clk);
        chk("t5_restart_sample", sample_out, 12'h888);
        chk("t5_restart_valid", sample_valid, 1);
        chk("t5_restart_overrun", overrun, 0);

`ifdef ADC_TIMEOUT_EN
        // No spi_ready: watchdog aborts after 1024 cycles in CONVERT
        wait_start(3000, n);
        t0 = cyc;
        for (int i = 1; i <= 1024; i++) begin
            @(negedge clk);
            if (i == 1024) begin
                chk("t6_cs_before", cs_n, 0);
                chk("t6_terr_before", timeout_err, 0);
            end
        end
        @(negedge clk);
        chk("t6_cs_after", cs_n, 1);
        chk("t6_terr_after", timeout_err, 1);
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) starts++;
        end
        chk("t6_no_sample", starts, 0);
        wait_start(3000, n);
        chk("t6_next_tick", cyc - t0, 2268);
        chk("t6_terr_sticky", timeout_err, 1);
`else
        chk("timeout_err_tied", timeout_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
